// File: rtl/opb_status_bank_if.sv
// OPB slave-side bus bundle for opb_status_bank.
// Master drives address/data/control; the slave returns data and acks.
interface opb_status_bank_if;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus,
    output OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_xferAck,
    input  Sl_errAck, Sl_retry, Sl_toutSup
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus,
    input  OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_xferAck,
    output Sl_errAck, Sl_retry, Sl_toutSup
  );
endinterface

// File: rtl/opb_status_bank.sv
// OPB slave exposing per-channel snapshot and sticky-OR status words.
// Single-cycle ack after the first hit, then waits for select to drop.
module opb_status_bank #(
  parameter logic [31:0] C_BASEADDR  = 32'h0108C100,
  parameter logic [31:0] C_HIGHADDR  = 32'h0108C1FF,
  parameter int          C_NUM_CH    = 4,
  parameter int          C_DWIDTH    = 32,
  parameter int          C_STICKY_EN = 1
) (
  input logic                         OPB_Clk,
  input logic                         OPB_Rst_n,
  opb_status_bank_if.slave            bus,
  input logic [C_NUM_CH*C_DWIDTH-1:0] user_data_in
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACK  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [1:0] state;
  logic [C_NUM_CH-1:0][C_DWIDTH-1:0] smp;
  logic [C_NUM_CH-1:0][C_DWIDTH-1:0] snap;
  logic [C_NUM_CH-1:0][C_DWIDTH-1:0] sticky;
  logic [15:0] snap_cnt;
  logic [31:0] addr;
  logic [31:0] off;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  be;
  logic [29:0] word;
  logic        hit;
  logic        ack;
  logic        ctrl_wr;
  logic        do_snap;
  logic        do_clr;
  logic        unused_bits;

  // Bus vectors are big-endian numbered; bit 31 lands on numeric bit 0.
  assign addr  = bus.OPB_ABus;
  assign wdata = bus.OPB_DBus;
  assign be    = bus.OPB_BE;
  assign off   = addr - C_BASEADDR;
  assign word  = off[31:2];

  assign hit = bus.OPB_select
            && addr >= C_BASEADDR
            && addr <= C_HIGHADDR;
  assign ack = state == ACK;

  assign ctrl_wr = ack && !bus.OPB_RNW
                && word == '0 && be[0];
  assign do_snap = ctrl_wr && wdata[0];
  assign do_clr  = ctrl_wr && wdata[1];

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE:    if (hit) state <= ACK;
        ACK:     state <= WAIT;
        WAIT:    if (!bus.OPB_select) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      smp      <= '0;
      snap     <= '0;
      sticky   <= '0;
      snap_cnt <= '0;
    end else begin
      smp    <= user_data_in;
      // Clear keeps the current sample so no event is lost.
      sticky <= do_clr ? smp : (sticky | smp);
      if (do_snap) begin
        snap     <= smp;
        snap_cnt <= snap_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (word == '0) rdata[15:0] = snap_cnt;
    for (int i = 0; i < C_NUM_CH; i++) begin
      if (word == 30'(i + 1))
        rdata[C_DWIDTH-1:0] = snap[i];
      if (C_STICKY_EN != 0 && word == 30'(i + 17))
        rdata[C_DWIDTH-1:0] = sticky[i];
    end
  end

  // Wired-OR bus: drive zero outside the read ack cycle.
  assign bus.Sl_DBus    = (ack && bus.OPB_RNW) ? rdata : '0;
  assign bus.Sl_xferAck = ack;
  assign bus.Sl_errAck  = 1'b0;
  assign bus.Sl_retry   = 1'b0;
  assign bus.Sl_toutSup = 1'b0;

  assign unused_bits = ^{bus.OPB_seqAddr, off[1:0],
                         be[3:1], wdata[31:2]};
endmodule
